// File: rtl/mac_accum_bank.sv
// Multi-channel guard-bit accumulator bank with a one-entry registered dump port.
// Optional output saturation is enabled by defining MAC_ACCUM_SAT_EN.
module mac_accum_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GUARD_BITS = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_BITS    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            in_op_i,
  input  logic [CH_BITS-1:0]    in_ch_i,
  input  logic [DATA_WIDTH-1:0] in_a_i,
  input  logic [DATA_WIDTH-1:0] in_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CH_BITS-1:0]    out_ch_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_sat_o
);

  localparam int unsigned AccW = DATA_WIDTH + GUARD_BITS;
  localparam logic [CH_BITS:0] NumChLim = NUM_CH[CH_BITS:0];

  localparam logic [2:0] OpMac   = 3'd0;
  localparam logic [2:0] OpLoad  = 3'd1;
  localparam logic [2:0] OpNeg   = 3'd2;
  localparam logic [2:0] OpHold  = 3'd3;
  localparam logic [2:0] OpClear = 3'd4;
  localparam logic [2:0] OpDump  = 3'd5;
  localparam logic [2:0] OpMsub  = 3'd6;
  localparam logic [2:0] OpAddab = 3'd7;

  logic [AccW-1:0]       acc_q [NUM_CH];
  logic [AccW-1:0]       acc_cur, acc_d, a_ext, b_ext;
  logic                  accept, ch_ok, dump_load;
  logic [CH_BITS-1:0]    ch_idx;
  logic [DATA_WIDTH-1:0] conv_data;
  logic                  conv_sat;

  logic                  out_valid_q, out_sat_q;
  logic [CH_BITS-1:0]    out_ch_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  // Stall everything while an unconsumed result occupies the output register.
  assign in_ready_o = !(out_valid_q && !out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign ch_ok      = {1'b0, in_ch_i} < NumChLim;
  assign ch_idx     = ch_ok ? in_ch_i : '0;
  assign acc_cur    = acc_q[ch_idx];
  assign a_ext      = {{GUARD_BITS{in_a_i[DATA_WIDTH-1]}}, in_a_i};
  assign b_ext      = {{GUARD_BITS{in_b_i[DATA_WIDTH-1]}}, in_b_i};
  assign dump_load  = accept && ch_ok && (in_op_i == OpDump);

  always_comb begin
    acc_d = acc_cur;
    case (in_op_i)
      OpMac:   acc_d = acc_cur + b_ext;
      OpLoad:  acc_d = b_ext;
      OpNeg:   acc_d = '0 - acc_cur;
      OpHold:  acc_d = acc_cur;
      OpClear: acc_d = '0;
      OpDump:  acc_d = '0;
      OpMsub:  acc_d = acc_cur - b_ext;
      OpAddab: acc_d = a_ext + b_ext;
      default: acc_d = acc_cur;
    endcase
  end

`ifdef MAC_ACCUM_SAT_EN
  logic acc_ovf;
  // In range only when every bit from the output sign bit upward matches the acc sign.
  assign acc_ovf = acc_cur[AccW-1:DATA_WIDTH-1] != {(GUARD_BITS + 1){acc_cur[AccW-1]}};

  always_comb begin
    conv_sat  = acc_ovf;
    conv_data = acc_cur[DATA_WIDTH-1:0];
    if (acc_ovf) begin
      conv_data = acc_cur[AccW-1] ? {1'b1, {(DATA_WIDTH - 1){1'b0}}}
                                  : {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
  end
`else
  assign conv_data = acc_cur[DATA_WIDTH-1:0];
  assign conv_sat  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else if (accept && ch_ok) begin
      acc_q[ch_idx] <= acc_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
    end else if (dump_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= conv_data;
      out_ch_q    <= in_ch_i;
      out_sat_q   <= conv_sat;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_sat_o   = out_sat_q;

endmodule

// File: doc/mac_accum_bank.md
# mac_accum_bank

Multi-channel multiply-accumulate accumulator bank for the MAC unit datapath; parametrised successor of the single-register accumulator. Holds NUM_CH independent guard-bit-extended accumulators. Each accepted operation updates one channel, selected by a channel index. Results are emitted through a registered valid/ready output port on a DUMP operation, with optional saturation to the data width. Sits between the multiplier output and the synthesis-filter/IMDCT result writeback.

## Interface
- DATA_WIDTH, 32, width of operands and output word (signed two's complement)
- GUARD_BITS, 8, extra accumulator MSBs; accumulator width ACC_W = DATA_WIDTH+GUARD_BITS
- NUM_CH, 4, number of accumulator channels (1..16)
- CH_BITS, 2, width of channel index; must satisfy 2^CH_BITS >= NUM_CH
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation this cycle
- in_op  in  3  operation code (see Operation)
- in_ch  in  CH_BITS  target channel
- in_a  in  DATA_WIDTH  addend operand, signed
- in_b  in  DATA_WIDTH  multiplier product operand, signed
- out_valid  out  1  out_data/out_ch/out_sat hold a dumped result
- out_ready  in  1  consumer accepts the result
- out_ch  out  CH_BITS  channel the result came from
- out_data  out  DATA_WIDTH  dumped result
- out_sat  out  1  result was clamped

## Operation
- Operation is accepted when in_valid && in_ready; it updates acc[in_ch] at that rising edge. a and b are sign-extended to ACC_W.
- in_op codes:
  - 0 MAC: acc <= acc + b
  - 1 LOAD: acc <= b
  - 2 NEG: acc <= 0 - acc
  - 3 HOLD: no change
  - 4 CLEAR: acc <= 0
  - 5 DUMP: output register <= conv(acc); acc <= 0
  - 6 MSUB: acc <= acc - b
  - 7 ADDAB: acc <= a + b
- All accumulator arithmetic wraps modulo 2^ACC_W. NEG of the most negative value yields itself.
- conv(): converts ACC_W to DATA_WIDTH (see Configuration). out_sat reflects the conversion.
- in_ch >= NUM_CH: the operation is accepted and has no effect. A DUMP to such a channel produces no output.
- Output register is one entry:
  - filled by an accepted DUMP;
  - freed when out_valid && out_ready.
- in_ready = !(out_valid && !out_ready) for all ops, including non-DUMP. An op is therefore stalled while a result sits unconsumed.
- Back-to-back: a DUMP accepted in the same cycle the old result drains loads the new result. out_valid stays 1.
- Channels are independent; consecutive ops to the same channel need no bubbles. Each op sees the result of the previous one.

## Timing
- Reset values:
  - all acc = 0;
  - out_valid = 0, out_data = 0, out_ch = 0, out_sat = 0;
  - in_ready = 1 after reset deasserts.
- Reset asserted mid-operation discards any pending output and all accumulator contents immediately (asynchronous).
- Update latency: an op accepted at edge N is visible in acc at edge N; the next op sees it.
- DUMP latency: accepted at edge N, so out_valid = 1 from edge N until the edge where out_ready is high.
- out_* are stable while out_valid && !out_ready.
- in_ready is combinational from out_valid/out_ready only. No path from in_valid to in_ready.

## Configuration
- MAC_ACCUM_SAT_EN defined:
  - conv() clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] when acc lies outside that range;
  - out_sat = 1 when clamping occurred, else 0.
- Not defined:
  - conv() returns acc[DATA_WIDTH-1:0] (truncation);
  - out_sat is tied to 0.

## Test plan
(DATA_WIDTH=16, GUARD_BITS=4, NUM_CH=4)
- Reset, then LOAD ch1 b=100, MAC ch1 b=-30, DUMP ch1 with out_ready=1 -> out_valid next edge, out_data=70, out_ch=1, out_sat=0; acc[1]=0 afterwards.
- Interleave MAC on ch0 (b=5) and ch3 (b=7), 3 times each, then DUMP both -> outputs 15 (ch0) then 21 (ch3). ch1/ch2 untouched (DUMP gives 0).
- LOAD ch2 b=32767, MAC ch2 b=32767, DUMP:
  - with MAC_ACCUM_SAT_EN -> out_data=32767, out_sat=1;
  - without -> out_data=-2 (0xFFFE), out_sat=0.
- Hold out_ready=0 after a DUMP:
  - in_ready=0, in_valid ops are not applied, out_* stable;
  - raise out_ready with a new DUMP pending -> both transfers occur at the same edge, second result presented next.
- ADDAB ch0 a=-8 b=3, then NEG ch0, DUMP -> out_data=5. in_ch=3 with NUM_CH=3 build: DUMP -> no out_valid.
- Assert reset while out_valid=1 and acc[0]=70 -> out_valid=0 immediately. A subsequent DUMP ch0 gives 0.
